// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data cache memory arbiter: FSM state
// encodings, owner codes and the grant-selection helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } owner_e;

    // Tie-break: fixed priority favours dc; round-robin favours whoever was not granted last.
    function automatic owner_e pick_owner(input logic ic_v, input logic dc_v,
                                          input logic rr_en, input owner_e last);
        owner_e g;
        if (ic_v && dc_v) begin
            if (rr_en) begin
                g = (last == OWNER_DC) ? OWNER_IC : OWNER_DC;
            end else begin
                g = OWNER_DC;
            end
        end else if (dc_v) begin
            g = OWNER_DC;
        end else begin
            g = OWNER_IC;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_arbiter_beat_cnt.sv
// Modulo-BEATS beat counter: increments per accepted beat, wraps to zero on
// the terminal beat, and flags when the current beat is the last of a line.
module mem_arbiter_beat_cnt #(
    parameter int BEATS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic terminal_o
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign terminal_o = (cnt_q == LAST);

    // Next count: clear, wrap on terminal beat, or step.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (inc_i) begin
            cnt_d = terminal_o ? {CW{1'b0}} : cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) arbiter onto a single main-memory port, one line
// transaction at a time. Define MEM_ARB_RR_EN for round-robin tie-breaking.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int BEATS     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic                   ic_req_rw,
    input  logic [ADDR_BITS-1:0]   ic_req_addr,
    input  logic                   ic_req_data_valid,
    output logic                   ic_req_data_ready,
    input  logic [DATA_BITS-1:0]   ic_req_data_bits,
    input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
    output logic                   ic_resp_valid,
    output logic [DATA_BITS-1:0]   ic_resp_data,
    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic                   dc_req_rw,
    input  logic [ADDR_BITS-1:0]   dc_req_addr,
    input  logic                   dc_req_data_valid,
    output logic                   dc_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
    output logic                   dc_resp_valid,
    output logic [DATA_BITS-1:0]   dc_resp_data,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_rw,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    owner_e grant_s;
`ifdef MEM_ARB_RR_EN
    owner_e last_q, last_d;
`endif

    logic                   own_rw_s;
    logic [ADDR_BITS-1:0]   own_addr_s;
    logic                   own_dv_s;
    logic [DATA_BITS-1:0]   own_bits_s;
    logic [DATA_BITS/8-1:0] own_mask_s;
    logic                   beat_inc_s;
    logic                   beat_last_s;
    logic                   cnt_clr_s;

    // Read data is a shared bus; only the matching resp_valid qualifies it.
    assign ic_resp_data = mem_resp_data;
    assign dc_resp_data = mem_resp_data;
    assign cnt_clr_s    = (state_q == ST_IDLE);

    mem_arbiter_beat_cnt #(
        .BEATS (BEATS)
    ) u_beat_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (cnt_clr_s),
        .inc_i      (beat_inc_s),
        .terminal_o (beat_last_s)
    );

    // Select the current owner's command and write-data fields.
    always_comb begin
        if (owner_q == OWNER_DC) begin
            own_rw_s   = dc_req_rw;
            own_addr_s = dc_req_addr;
            own_dv_s   = dc_req_data_valid;
            own_bits_s = dc_req_data_bits;
            own_mask_s = dc_req_data_mask;
        end else begin
            own_rw_s   = ic_req_rw;
            own_addr_s = ic_req_addr;
            own_dv_s   = ic_req_data_valid;
            own_bits_s = ic_req_data_bits;
            own_mask_s = ic_req_data_mask;
        end
    end

    // Arbitration decision for the IDLE cycle.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        grant_s = pick_owner(ic_req_valid, dc_req_valid, 1'b1, last_q);
`else
        grant_s = pick_owner(ic_req_valid, dc_req_valid, 1'b0, OWNER_DC);
`endif
    end

    // State, owner and grant-history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_DC;
`ifdef MEM_ARB_RR_EN
            last_q  <= OWNER_DC;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifdef MEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Next-state logic; beats are counted on write-data handshakes or read beats.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_inc_s = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d     = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ic_req_valid || dc_req_valid) begin
                    owner_d = grant_s;
                    state_d = ST_REQ;
`ifdef MEM_ARB_RR_EN
                    last_d  = grant_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = own_rw_s ? ST_WDATA : ST_RESP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WDATA: begin
                beat_inc_s = own_dv_s && mem_req_data_ready;
                if (beat_inc_s && beat_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_RESP: begin
                beat_inc_s = mem_resp_valid;
                if (beat_inc_s && beat_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output steering: everything idle except the owner's active channel.
    always_comb begin
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = {ADDR_BITS{1'b0}};
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = {DATA_BITS{1'b0}};
        mem_req_data_mask  = {(DATA_BITS/8){1'b0}};
        ic_req_ready       = 1'b0;
        dc_req_ready       = 1'b0;
        ic_req_data_ready  = 1'b0;
        dc_req_data_ready  = 1'b0;
        ic_resp_valid      = 1'b0;
        dc_resp_valid      = 1'b0;
        case (state_q)
            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = own_rw_s;
                mem_req_addr  = own_addr_s;
                if (owner_q == OWNER_DC) begin
                    dc_req_ready = mem_req_ready;
                end else begin
                    ic_req_ready = mem_req_ready;
                end
            end
            ST_WDATA: begin
                mem_req_data_valid = own_dv_s;
                mem_req_data_bits  = own_bits_s;
                mem_req_data_mask  = own_mask_s;
                if (owner_q == OWNER_DC) begin
                    dc_req_data_ready = mem_req_data_ready;
                end else begin
                    ic_req_data_ready = mem_req_data_ready;
                end
            end
            ST_RESP: begin
                if (owner_q == OWNER_DC) begin
                    dc_resp_valid = mem_resp_valid;
                end else begin
                    ic_resp_valid = mem_resp_valid;
                end
            end
            default: begin
                mem_req_valid = 1'b0;
            end
        endcase
    end

endmodule
